me_unit: RTL and testbench
==========================

ME_UNIT -- requirements
Module: me_unit

Interface
- REQ-001: Parameters SHALL be none; bus widths come from shared macros `EX_to_ME_Bus_Size (76) and `ME_to_WB_Bus_Size (70).
- REQ-002: clk  input  1  single clock; all state updates on posedge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: EX_to_ME_Valid  input  1  EX holds a completed instruction.
- REQ-005: EX_to_ME_Bus  input  76  {dest_flag[75:71], pc[70:39], alu_result[38:7], res_from_mem[6], gr_we[5], dest[4:0]}; dest_flag = {signed, is_byte, is_half, offset[1:0]}.
- REQ-006: ME_Allow_in  output  1  ME can accept EX's instruction this cycle.
- REQ-007: data_sram_rdata  input  32  synchronous SRAM read data, valid only the cycle after EX issued the request.
- REQ-008: ME_to_WB_Valid  output  1  ME holds a finished instruction for WB.
- REQ-009: WB_Allow_in  input  1  WB can accept.
- REQ-010: ME_to_WB_Bus  output  70  {pc[69:38], final_result[37:6], gr_we[5], dest[4:0]}.
- REQ-011: ME_dest  output  5  dest masked by ME_Valid and gr_we, for ID hazard check.
- REQ-012: ME_Forward_Res  output  32  forwarding value to ID.
- REQ-013: ME_to_ID_Ld_op  output  1  ME_Valid and res_from_mem and forwarding of load data unavailable.

Function
- REQ-014: ME_ReadyGo SHALL be 1; ME_Allow_in = !ME_Valid || WB_Allow_in; ME_to_WB_Valid = ME_Valid.
- REQ-015: On ME_Allow_in, ME_Valid SHALL load EX_to_ME_Valid; bus fields SHALL latch only when ME_Allow_in && EX_to_ME_Valid.
- REQ-016: A first_cycle flag SHALL set on every bus latch and clear the following cycle.
- REQ-017: In first_cycle with ME_Valid && res_from_mem, data_sram_rdata SHALL be captured into rdata_buf and rdata_buf_valid set.
- REQ-018: Load data source SHALL be data_sram_rdata in first_cycle, else rdata_buf; rdata_buf_valid SHALL clear on next bus latch or when ME empties.
- REQ-019: Extraction: byte selects rdata[8*offset+7 : 8*offset]; half selects [15:0] (offset[1]=0) or [31:16] (offset[1]=1); neither flag -> full word; signed -> sign-extend, else zero-extend.
- REQ-020: final_result SHALL be extracted load data when res_from_mem, else alu_result.
- REQ-021: Stall with WB_Allow_in=0 for N cycles SHALL keep bus, ME_to_WB_Bus and final_result stable, regardless of data_sram_rdata changes.
- REQ-022: Simultaneous drain and fill (ME_Valid, WB_Allow_in=1, EX_to_ME_Valid=1) SHALL replace contents in one cycle with no bubble.
- REQ-023: ME_dest SHALL be 0 when ME_Valid=0 or gr_we=0.

Reset
- REQ-024: reset SHALL clear ME_Valid, first_cycle, rdata_buf_valid; outputs then read ME_to_WB_Valid=0, ME_Allow_in=1, ME_dest=0, ME_to_ID_Ld_op=0.
- REQ-025: Reset mid-stall SHALL discard the held instruction; no WB handoff afterwards.

Configuration
- REQ-026: Macro ME_LOAD_FORWARD_EN defined: ME_Forward_Res = final_result and ME_to_ID_Ld_op = 0.
- REQ-027: ME_LOAD_FORWARD_EN undefined: ME_Forward_Res = alu_result and ME_to_ID_Ld_op = ME_Valid && res_from_mem (ID stalls).

Structure
- REQ-028: Bus-size macros and dest_flag bit positions SHALL live in my_cpu.vh.
- REQ-029: Extraction SHALL be a combinational sub-module load_ext (rdata, dest_flag -> data).

Verification
- REQ-030: ld.b signed, offset 3, rdata 0x80FF_1234 -> final_result 0xFFFF_FF80.
- REQ-031: ld.hu, offset 2, rdata 0x9ABC_5678 -> final_result 0x0000_9ABC; ld.h offset 0 same rdata -> 0x0000_5678.
- REQ-032: ld.w, WB_Allow_in=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after first cycle -> WB receives first-cycle value 0x1122_3344.
- REQ-033: back-to-back add (alu 0x10, dest 5) then ld.w, WB_Allow_in=1 -> ME_to_WB_Valid high both cycles, ME_dest 5 then load dest.
- REQ-034: reset asserted during stall -> next cycle ME_to_WB_Valid=0, ME_Allow_in=1, ME_dest=0.
- REQ-035: ld.w in ME with and without ME_LOAD_FORWARD_EN -> ME_to_ID_Ld_op 0/load data forwarded vs 1/alu_result forwarded.

Source files
------------

// File: rtl/me_unit_pkg.sv
// Types shared by the memory-access stage: EX->ME and ME->WB bus layouts.
`include "my_cpu.vh"

package me_unit_pkg;

    localparam int EX_BUS_W = `EX_to_ME_Bus_Size;
    localparam int WB_BUS_W = `ME_to_WB_Bus_Size;

    typedef struct packed {
        logic [4:0]  dest_flag;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } ex_me_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_result;
        logic        gr_we;
        logic [4:0]  dest;
    } me_wb_bus_t;

endpackage

// File: rtl/load_ext.sv
// Combinational load extraction: picks byte/half/word from the SRAM word and extends it.
`include "my_cpu.vh"

module load_ext (
    input  logic [31:0] rdata,
    input  logic [4:0]  dest_flag,
    output logic [31:0] data
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    logic       sgn;
    logic [1:0] offset;
    logic [7:0] byte_sel;

    assign sgn    = dest_flag[`DF_SIGNED];
    assign offset = dest_flag[`DF_OFF_HI:`DF_OFF_LO];

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    always_comb begin
        data = rdata;
        if (dest_flag[`DF_BYTE])
            data = ext_byte(byte_sel, sgn);
        else if (dest_flag[`DF_HALF])
            data = ext_half(offset[1] ? rdata[31:16] : rdata[15:0], sgn);
    end

endmodule

// File: rtl/my_cpu.vh
// Shared pipeline bus widths and dest_flag bit positions for the CPU stages.
`ifndef MY_CPU_VH
`define MY_CPU_VH

`define EX_to_ME_Bus_Size 76
`define ME_to_WB_Bus_Size 70

// dest_flag = {signed, is_byte, is_half, offset[1:0]}
`define DF_SIGNED 4
`define DF_BYTE   3
`define DF_HALF   2
`define DF_OFF_HI 1
`define DF_OFF_LO 0

`endif

// File: rtl/me_unit.sv
// Memory-access pipeline stage: holds one instruction, merges load data, hands off to WB.
// Optional macro ME_LOAD_FORWARD_EN forwards extracted load data to ID instead of stalling it.
`include "my_cpu.vh"

module me_unit
    import me_unit_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           EX_to_ME_Valid,
    input  logic [`EX_to_ME_Bus_Size-1:0]  EX_to_ME_Bus,
    output logic                           ME_Allow_in,
    input  logic [31:0]                    data_sram_rdata,
    output logic                           ME_to_WB_Valid,
    input  logic                           WB_Allow_in,
    output logic [`ME_to_WB_Bus_Size-1:0]  ME_to_WB_Bus,
    output logic [4:0]                     ME_dest,
    output logic [31:0]                    ME_Forward_Res,
    output logic                           ME_to_ID_Ld_op
);

    ex_me_bus_t  bus_p1;
    me_wb_bus_t  wb_bus;
    logic        vld_p1;
    logic        first_cycle_p1;
    logic        rdata_buf_vld_p1;
    logic [31:0] rdata_buf_p1;
    logic        latch;
    logic        capture;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ME_Allow_in    = !vld_p1 || WB_Allow_in;
    assign ME_to_WB_Valid = vld_p1;
    assign latch          = ME_Allow_in && EX_to_ME_Valid;
    assign capture        = first_cycle_p1 && vld_p1 && bus_p1.res_from_mem;

    // Stage boundary EX -> ME: control state
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1           <= 1'b0;
            first_cycle_p1   <= 1'b0;
            rdata_buf_vld_p1 <= 1'b0;
        end else begin
            if (ME_Allow_in)
                vld_p1 <= EX_to_ME_Valid;
            first_cycle_p1 <= latch;
            // Leaving the stage (drain or refill) invalidates the held load word.
            if (ME_Allow_in)
                rdata_buf_vld_p1 <= 1'b0;
            else if (capture)
                rdata_buf_vld_p1 <= 1'b1;
        end
    end

    // Stage boundary EX -> ME: datapath registers, no reset
    always_ff @(posedge clk) begin
        if (latch)
            bus_p1 <= EX_to_ME_Bus;
        if (capture)
            rdata_buf_p1 <= data_sram_rdata;
    end

    // SRAM data is only valid in the first cycle; afterwards the buffered copy is used.
    assign load_src = rdata_buf_vld_p1 ? rdata_buf_p1 : data_sram_rdata;

    load_ext u_load_ext (
        .rdata     (load_src),
        .dest_flag (bus_p1.dest_flag),
        .data      (load_data)
    );

    assign final_result = bus_p1.res_from_mem ? load_data : bus_p1.alu_result;

    always_comb begin
        wb_bus              = '0;
        wb_bus.pc           = bus_p1.pc;
        wb_bus.final_result = final_result;
        wb_bus.gr_we        = bus_p1.gr_we;
        wb_bus.dest         = bus_p1.dest;
    end

    assign ME_to_WB_Bus = wb_bus;
    assign ME_dest      = (vld_p1 && bus_p1.gr_we) ? bus_p1.dest : 5'd0;

`ifdef ME_LOAD_FORWARD_EN
    assign ME_Forward_Res = final_result;
    assign ME_to_ID_Ld_op = 1'b0;
`else
    assign ME_Forward_Res = bus_p1.alu_result;
    assign ME_to_ID_Ld_op = vld_p1 && bus_p1.res_from_mem;
`endif

endmodule

// File: tb/tb_me_unit.sv
// Directed bench for me_unit: load extraction, stall hold, back-to-back flow, reset, forwarding.
module tb_me_unit;

    logic        clk;
    logic        reset;
    logic        EX_to_ME_Valid;
    logic [75:0] EX_to_ME_Bus;
    logic        ME_Allow_in;
    logic [31:0] data_sram_rdata;
    logic        ME_to_WB_Valid;
    logic        WB_Allow_in;
    logic [69:0] ME_to_WB_Bus;
    logic [4:0]  ME_dest;
    logic [31:0] ME_Forward_Res;
    logic        ME_to_ID_Ld_op;

    int checks = 0;
    int errors = 0;

    me_unit dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_ME_Valid  (EX_to_ME_Valid),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .ME_Allow_in     (ME_Allow_in),
        .data_sram_rdata (data_sram_rdata),
        .ME_to_WB_Valid  (ME_to_WB_Valid),
        .WB_Allow_in     (WB_Allow_in),
        .ME_to_WB_Bus    (ME_to_WB_Bus),
        .ME_dest         (ME_dest),
        .ME_Forward_Res  (ME_Forward_Res),
        .ME_to_ID_Ld_op  (ME_to_ID_Ld_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] mk_bus(input logic [4:0] flag, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic rfm,
                                           input logic we, input logic [4:0] dest);
        return {flag, pc, alu, rfm, we, dest};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one EX instruction and let it latch; EX valid drops after the edge.
    task automatic issue(input logic [75:0] bus);
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = bus;
        @(posedge clk);
        #1;
        EX_to_ME_Valid = 1'b0;
    endtask

    // Forwarding expectations for a load resident in ME.
    task automatic chk_fwd_load(input string tag, input logic [31:0] ld_val, input logic [31:0] alu);
`ifdef ME_LOAD_FORWARD_EN
        chk({tag, "_ldop"}, {31'd0, ME_to_ID_Ld_op}, 32'd0);
        chk({tag, "_fwd"}, ME_Forward_Res, ld_val);
`else
        chk({tag, "_ldop"}, {31'd0, ME_to_ID_Ld_op}, 32'd1);
        chk({tag, "_fwd"}, ME_Forward_Res, alu);
`endif
    endtask

    initial begin
        reset           = 1'b1;
        EX_to_ME_Valid  = 1'b0;
        EX_to_ME_Bus    = '0;
        data_sram_rdata = 32'h0;
        WB_Allow_in     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, ME_to_WB_Valid}, 32'd0);
        chk("rst_allow_in", {31'd0, ME_Allow_in}, 32'd1);
        chk("rst_dest", {27'd0, ME_dest}, 32'd0);
        chk("rst_ldop", {31'd0, ME_to_ID_Ld_op}, 32'd0);
        reset = 1'b0;

        // ld.b signed, offset 3
        issue(mk_bus(5'b11011, 32'h0000_1000, 32'h0000_1003, 1'b1, 1'b1, 5'd7));
        data_sram_rdata = 32'h80FF_1234;
        @(negedge clk);
        chk("ldb_valid", {31'd0, ME_to_WB_Valid}, 32'd1);
        chk("ldb_result", ME_to_WB_Bus[37:6], 32'hFFFF_FF80);
        chk("ldb_pc", ME_to_WB_Bus[69:38], 32'h0000_1000);
        chk("ldb_dest", {27'd0, ME_dest}, 32'd7);
        chk_fwd_load("ldb", 32'hFFFF_FF80, 32'h0000_1003);

        // ld.hu, offset 2
        issue(mk_bus(5'b00110, 32'h0000_1004, 32'h0000_2002, 1'b1, 1'b1, 5'd8));
        data_sram_rdata = 32'h9ABC_5678;
        @(negedge clk);
        chk("ldhu_result", ME_to_WB_Bus[37:6], 32'h0000_9ABC);

        // ld.h signed, offset 0
        issue(mk_bus(5'b10100, 32'h0000_1008, 32'h0000_2000, 1'b1, 1'b1, 5'd8));
        data_sram_rdata = 32'h9ABC_5678;
        @(negedge clk);
        chk("ldh_result", ME_to_WB_Bus[37:6], 32'h0000_5678);

        // ld.h signed, offset 2 (negative half)
        issue(mk_bus(5'b10110, 32'h0000_100C, 32'h0000_2002, 1'b1, 1'b1, 5'd8));
        data_sram_rdata = 32'h9ABC_5678;
        @(negedge clk);
        chk("ldh_neg_result", ME_to_WB_Bus[37:6], 32'hFFFF_9ABC);

        // ld.bu, offset 1
        issue(mk_bus(5'b01001, 32'h0000_1010, 32'h0000_3001, 1'b1, 1'b1, 5'd9));
        data_sram_rdata = 32'h80FF_1234;
        @(negedge clk);
        chk("ldbu_result", ME_to_WB_Bus[37:6], 32'h0000_0012);

        // ld.b signed, offset 2 -> 0xFF
        issue(mk_bus(5'b11010, 32'h0000_1014, 32'h0000_3002, 1'b1, 1'b1, 5'd9));
        data_sram_rdata = 32'h80FF_1234;
        @(negedge clk);
        chk("ldb2_result", ME_to_WB_Bus[37:6], 32'hFFFF_FFFF);

        // store-like op with gr_we=0: ME_dest masked
        issue(mk_bus(5'b00000, 32'h0000_1018, 32'h0000_0044, 1'b0, 1'b0, 5'd4));
        @(negedge clk);
        chk("nowe_dest", {27'd0, ME_dest}, 32'd0);
        chk("nowe_result", ME_to_WB_Bus[37:6], 32'h0000_0044);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("empty_valid", {31'd0, ME_to_WB_Valid}, 32'd0);

        // ld.w stalled 3 cycles; SRAM data changes after the first cycle
        WB_Allow_in = 1'b0;
        issue(mk_bus(5'b00000, 32'h0000_2000, 32'h0000_4000, 1'b1, 1'b1, 5'd10));
        data_sram_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("stall_c1_result", ME_to_WB_Bus[37:6], 32'h1122_3344);
        chk("stall_c1_allow", {31'd0, ME_Allow_in}, 32'd0);
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(5'b00000, 32'h0000_9999, 32'h0000_5555, 1'b0, 1'b1, 5'd11);
        @(posedge clk);
        #1;
        data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_c2_result", ME_to_WB_Bus[37:6], 32'h1122_3344);
        chk("stall_c2_pc", ME_to_WB_Bus[69:38], 32'h0000_2000);
        @(posedge clk);
        #1;
        EX_to_ME_Valid = 1'b0;
        WB_Allow_in    = 1'b1;
        @(negedge clk);
        chk("stall_c3_result", ME_to_WB_Bus[37:6], 32'h1122_3344);
        chk("stall_c3_valid", {31'd0, ME_to_WB_Valid}, 32'd1);
        chk("stall_c3_dest", {27'd0, ME_dest}, 32'd10);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_valid", {31'd0, ME_to_WB_Valid}, 32'd0);
        chk("drain_dest", {27'd0, ME_dest}, 32'd0);

        // back-to-back add then ld.w, no bubble
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(5'b00000, 32'h0000_3000, 32'h0000_0010, 1'b0, 1'b1, 5'd5);
        @(posedge clk);
        #1;
        EX_to_ME_Bus   = mk_bus(5'b00000, 32'h0000_3004, 32'h0000_6000, 1'b1, 1'b1, 5'd6);
        @(negedge clk);
        chk("b2b_add_valid", {31'd0, ME_to_WB_Valid}, 32'd1);
        chk("b2b_add_dest", {27'd0, ME_dest}, 32'd5);
        chk("b2b_add_result", ME_to_WB_Bus[37:6], 32'h0000_0010);
        chk("b2b_add_ldop", {31'd0, ME_to_ID_Ld_op}, 32'd0);
        chk("b2b_add_fwd", ME_Forward_Res, 32'h0000_0010);
        @(posedge clk);
        #1;
        EX_to_ME_Valid  = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b2b_ld_valid", {31'd0, ME_to_WB_Valid}, 32'd1);
        chk("b2b_ld_dest", {27'd0, ME_dest}, 32'd6);
        chk("b2b_ld_result", ME_to_WB_Bus[37:6], 32'hCAFE_F00D);
        chk_fwd_load("b2b_ld", 32'hCAFE_F00D, 32'h0000_6000);
        @(posedge clk);
        #1;

        // reset during a stall discards the held instruction
        WB_Allow_in = 1'b0;
        issue(mk_bus(5'b00000, 32'h0000_4000, 32'h0000_7000, 1'b1, 1'b1, 5'd3));
        data_sram_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("rst_stall_pre_valid", {31'd0, ME_to_WB_Valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_stall_valid", {31'd0, ME_to_WB_Valid}, 32'd0);
        chk("rst_stall_allow", {31'd0, ME_Allow_in}, 32'd1);
        chk("rst_stall_dest", {27'd0, ME_dest}, 32'd0);
        chk("rst_stall_ldop", {31'd0, ME_to_ID_Ld_op}, 32'd0);
        WB_Allow_in = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall_no_handoff", {31'd0, ME_to_WB_Valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
